calendar_date_counter: RTL and testbench

CALENDAR_DATE_COUNTER -- requirements
Module: calendar_date_counter

---
 rtl/calendar_date_counter_if.sv | 42 ++++
 rtl/calendar_date_counter.sv | 172 +++++++++++++++++
 tb/tb_calendar_date_counter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/calendar_date_counter_if.sv
// Calendar date counter bus.
// Groups the time-of-day inputs, edit controls and date outputs of
// calendar_date_counter. The clock and reset stay plain module ports.
//   master : drives sec/min/hour/mode/btn_up/btn_down, observes the date
//   slave  : the counter itself
// Optional feature macro: DATE_WEEKDAY_EN adds the wday field.
interface calendar_date_counter_if #(
    parameter int YEAR_W = 13
);
    logic [5:0]        sec;
    logic [5:0]        min;
    logic [4:0]        hour;
    logic [2:0]        mode;
    logic              btn_up;
    logic              btn_down;
    logic [4:0]        day;
    logic [3:0]        mont;
    logic [YEAR_W-1:0] year;
    logic              leap;
    logic              century_wrap;
`ifdef DATE_WEEKDAY_EN
    logic [2:0]        wday;

    modport master (
        output sec, min, hour, mode, btn_up, btn_down,
        input  day, mont, year, leap, century_wrap, wday
    );
    modport slave (
        input  sec, min, hour, mode, btn_up, btn_down,
        output day, mont, year, leap, century_wrap, wday
    );
`else
    modport master (
        output sec, min, hour, mode, btn_up, btn_down,
        input  day, mont, year, leap, century_wrap
    );
    modport slave (
        input  sec, min, hour, mode, btn_up, btn_down,
        output day, mont, year, leap, century_wrap
    );
`endif
endinterface

// File: rtl/calendar_date_counter.sv
// Calendar date counter.
// Advances day/month/year once per day (at 23:59:59 in run mode) and lets the
// user edit each field with active-low up/down buttons.
// Ports:
//   clk_1Hz : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : calendar_date_counter_if.slave (time inputs, mode, buttons,
//             day/mont/year/leap/century_wrap outputs, wday when enabled)
// Optional feature macro: DATE_WEEKDAY_EN adds a weekday register (mode 110
// edits it, it advances mod 7 every day). Without it mode 110 means run.
module calendar_date_counter #(
    parameter int YEAR_W     = 13,
    parameter int YEAR_MIN   = 2000,
    parameter int YEAR_MAX   = 2099,
    parameter int RESET_YEAR = 2001,
    parameter int RESET_WDAY = 1
) (
    input logic                  clk_1Hz,
    input logic                  rst_n,
    calendar_date_counter_if.slave bus
);
    localparam logic [YEAR_W-1:0] Y_MIN   = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX   = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RESET = YEAR_W'(RESET_YEAR);
    localparam logic [YEAR_W-1:0] Y_ONE   = YEAR_W'(1);

    // Gregorian leap-year rule.
    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int unsigned yi;
        yi = 32'(y);
        return ((yi % 32'd4) == 32'd0) &&
               (((yi % 32'd100) != 32'd0) || ((yi % 32'd400) == 32'd0));
    endfunction

    // Number of days in month m, given the leap flag of its year.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic lp);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = lp ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    logic [4:0]        day_r, day_nxt_s;
    logic [3:0]        mont_r, mont_nxt_s;
    logic [YEAR_W-1:0] year_r, year_nxt_s;
    logic              cw_r, cw_nxt_s;
    logic              leap_s;
    logic [4:0]        dim_s;
    logic [4:0]        new_dim_s;
    logic              day_edit_s, mont_edit_s, year_edit_s, wday_edit_s;
    logic              run_s, eod_s, up_s, dn_s;
`ifdef DATE_WEEKDAY_EN
    logic [2:0]        wday_r, wday_nxt_s;
`endif

    assign leap_s      = is_leap(year_r);
    assign dim_s       = days_in_month(mont_r, leap_s);
    assign day_edit_s  = (bus.mode == 3'b011);
    assign mont_edit_s = (bus.mode == 3'b100);
    assign year_edit_s = (bus.mode == 3'b101);
`ifdef DATE_WEEKDAY_EN
    assign wday_edit_s = (bus.mode == 3'b110);
`else
    assign wday_edit_s = 1'b0;
`endif
    assign run_s = ~(day_edit_s | mont_edit_s | year_edit_s | wday_edit_s);
    // Exact compare: out-of-range time values can never look like end of day.
    assign eod_s = run_s && (bus.sec == 6'd59) && (bus.min == 6'd59) && (bus.hour == 5'd23);
    // Buttons are active low; up wins when both are pressed.
    assign up_s = ~bus.btn_up;
    assign dn_s = bus.btn_up & ~bus.btn_down;

    // Next-state computation for natural advance and field edits.
    always_comb begin
        day_nxt_s  = day_r;
        mont_nxt_s = mont_r;
        year_nxt_s = year_r;
        cw_nxt_s   = 1'b0;
        new_dim_s  = dim_s;
`ifdef DATE_WEEKDAY_EN
        wday_nxt_s = wday_r;
`endif
        if (eod_s) begin
            if (day_r < dim_s) begin
                day_nxt_s = day_r + 5'd1;
            end else begin
                day_nxt_s = 5'd1;
                if (mont_r < 4'd12) begin
                    mont_nxt_s = mont_r + 4'd1;
                end else begin
                    mont_nxt_s = 4'd1;
                    if (year_r < Y_MAX) begin
                        year_nxt_s = year_r + Y_ONE;
                    end else begin
                        year_nxt_s = Y_MIN;
                        cw_nxt_s   = 1'b1;
                    end
                end
            end
`ifdef DATE_WEEKDAY_EN
            wday_nxt_s = (wday_r >= 3'd6) ? 3'd0 : wday_r + 3'd1;
`endif
        end else if (day_edit_s && (up_s || dn_s)) begin
            if (up_s) begin
                day_nxt_s = (day_r >= dim_s) ? 5'd1 : day_r + 5'd1;
            end else begin
                day_nxt_s = (day_r <= 5'd1) ? dim_s : day_r - 5'd1;
            end
        end else if (mont_edit_s && (up_s || dn_s)) begin
            if (up_s) begin
                mont_nxt_s = (mont_r >= 4'd12) ? 4'd1 : mont_r + 4'd1;
            end else begin
                mont_nxt_s = (mont_r <= 4'd1) ? 4'd12 : mont_r - 4'd1;
            end
            // Keep the day legal for the month just selected.
            new_dim_s = days_in_month(mont_nxt_s, leap_s);
            day_nxt_s = (day_r > new_dim_s) ? new_dim_s : day_r;
        end else if (year_edit_s && (up_s || dn_s)) begin
            if (up_s) begin
                year_nxt_s = (year_r >= Y_MAX) ? Y_MIN : year_r + Y_ONE;
            end else begin
                year_nxt_s = (year_r <= Y_MIN) ? Y_MAX : year_r - Y_ONE;
            end
            // Only 29 Feb can become illegal when the year changes.
            new_dim_s = days_in_month(mont_r, is_leap(year_nxt_s));
            day_nxt_s = (day_r > new_dim_s) ? new_dim_s : day_r;
`ifdef DATE_WEEKDAY_EN
        end else if (wday_edit_s && (up_s || dn_s)) begin
            if (up_s) begin
                wday_nxt_s = (wday_r >= 3'd6) ? 3'd0 : wday_r + 3'd1;
            end else begin
                wday_nxt_s = (wday_r == 3'd0) ? 3'd6 : wday_r - 3'd1;
            end
`endif
        end else begin
            day_nxt_s = day_r;
        end
    end

    // Date registers with asynchronous reset.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            day_r  <= 5'd1;
            mont_r <= 4'd1;
            year_r <= Y_RESET;
            cw_r   <= 1'b0;
`ifdef DATE_WEEKDAY_EN
            wday_r <= 3'(RESET_WDAY);
`endif
        end else begin
            day_r  <= day_nxt_s;
            mont_r <= mont_nxt_s;
            year_r <= year_nxt_s;
            cw_r   <= cw_nxt_s;
`ifdef DATE_WEEKDAY_EN
            wday_r <= wday_nxt_s;
`endif
        end
    end

    assign bus.day          = day_r;
    assign bus.mont         = mont_r;
    assign bus.year         = year_r;
    assign bus.leap         = leap_s;
    assign bus.century_wrap = cw_r;
`ifdef DATE_WEEKDAY_EN
    assign bus.wday         = wday_r;
`endif
endmodule

// File: tb/tb_calendar_date_counter.sv
// Randomized + directed bench for calendar_date_counter. Two instances share
// the stimulus: one with YEAR_MAX 2099, one with YEAR_MAX 2100. A calendar
// reference model predicts each clock edge; predictions are queued and a
// monitor compares them against the outputs just after each rising edge.
module tb_calendar_date_counter;
    localparam int YMIN = 2000;

    typedef struct {
        int day;
        int mon;
        int year;
        int wday;
        bit leap;
        bit cw;
    } date_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ymax[2] = '{2099, 2100};
    date_t st[2];
    date_t q0[$];
    date_t q1[$];

    calendar_date_counter_if #(.YEAR_W(13)) bus0 ();
    calendar_date_counter_if #(.YEAR_W(13)) bus1 ();

    calendar_date_counter #(.YEAR_MAX(2099)) u_dut0 (.clk_1Hz(clk), .rst_n(rst_n), .bus(bus0));
    calendar_date_counter #(.YEAR_MAX(2100)) u_dut1 (.clk_1Hz(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    function automatic bit leap_of(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int mdays(input int m, input int y);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return tbl[m-1] + ((m == 2 && leap_of(y)) ? 1 : 0);
    endfunction

    function automatic int wrapv(input int v, input int lo, input int hi);
        if (v > hi) return lo;
        if (v < lo) return hi;
        return v;
    endfunction

    function automatic date_t reset_state();
        date_t r;
        r.day = 1; r.mon = 1; r.year = 2001; r.wday = 1;
        r.leap = leap_of(2001); r.cw = 1'b0;
        return r;
    endfunction

    // Calendar rules applied to one clock edge.
    function automatic date_t model_next(input date_t s, input int ym, input int sc, input int mi,
                                         input int hr, input int md, input bit bu, input bit bd);
        date_t n;
        bit wk;
        int stp;
        n = s;
        n.cw = 1'b0;
`ifdef DATE_WEEKDAY_EN
        wk = (md == 6);
`else
        wk = 1'b0;
`endif
        stp = !bu ? 1 : (!bd ? -1 : 0);
        if (!(md == 3 || md == 4 || md == 5 || wk)) begin
            if (sc == 59 && mi == 59 && hr == 23) begin
                n.day = s.day + 1;
                if (n.day > mdays(s.mon, s.year)) begin
                    n.day = 1;
                    n.mon = s.mon + 1;
                    if (n.mon > 12) begin
                        n.mon = 1;
                        n.year = s.year + 1;
                        if (n.year > ym) begin
                            n.year = YMIN;
                            n.cw = 1'b1;
                        end
                    end
                end
                n.wday = (s.wday + 1) % 7;
            end
        end else if (stp != 0) begin
            case (md)
                3: n.day = wrapv(s.day + stp, 1, mdays(s.mon, s.year));
                4: begin
                    n.mon = wrapv(s.mon + stp, 1, 12);
                    if (n.day > mdays(n.mon, n.year)) n.day = mdays(n.mon, n.year);
                end
                5: begin
                    n.year = wrapv(s.year + stp, YMIN, ym);
                    if (n.day > mdays(n.mon, n.year)) n.day = mdays(n.mon, n.year);
                end
                default: n.wday = (s.wday + stp + 7) % 7;
            endcase
        end
        n.leap = leap_of(n.year);
        return n;
    endfunction

    task automatic check_out(input int k, input date_t e, input int ad, input int am, input int ay,
                             input bit al, input bit ac, input int aw);
        bit ok;
        ok = (ad == e.day) && (am == e.mon) && (ay == e.year) && (al == e.leap) && (ac == e.cw);
`ifdef DATE_WEEKDAY_EN
        ok = ok && (aw == e.wday);
`endif
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL dut%0d date at %0t: got d=%0d m=%0d y=%0d leap=%0d cw=%0d wday=%0d, expected d=%0d m=%0d y=%0d leap=%0d cw=%0d wday=%0d",
                     k, $time, ad, am, ay, al, ac, aw, e.day, e.mon, e.year, e.leap, e.cw, e.wday);
        end
    endtask

    task automatic check_now(input date_t e0, input date_t e1);
        int w0, w1;
`ifdef DATE_WEEKDAY_EN
        w0 = int'(bus0.wday); w1 = int'(bus1.wday);
`else
        w0 = 0; w1 = 0;
`endif
        check_out(0, e0, int'(bus0.day), int'(bus0.mont), int'(bus0.year), bus0.leap, bus0.century_wrap, w0);
        check_out(1, e1, int'(bus1.day), int'(bus1.mont), int'(bus1.year), bus1.leap, bus1.century_wrap, w1);
    endtask

    // Monitor: compare the queued prediction just after every rising edge.
    always @(posedge clk) begin
        #1;
        if (q0.size() > 0 && q1.size() > 0) begin
            check_now(q0.pop_front(), q1.pop_front());
        end
    end

    // Predict the coming edge from the inputs currently applied.
    task automatic push_expected();
        for (int k = 0; k < 2; k++) begin
            st[k] = model_next(st[k], ymax[k], int'(bus0.sec), int'(bus0.min), int'(bus0.hour),
                               int'(bus0.mode), bus0.btn_up, bus0.btn_down);
        end
        q0.push_back(st[0]);
        q1.push_back(st[1]);
    endtask

    task automatic drive(input logic [5:0] s, input logic [5:0] mi, input logic [4:0] h,
                         input logic [2:0] md, input logic bu, input logic bd);
        @(negedge clk);
        bus0.sec = s; bus0.min = mi; bus0.hour = h; bus0.mode = md; bus0.btn_up = bu; bus0.btn_down = bd;
        bus1.sec = s; bus1.min = mi; bus1.hour = h; bus1.mode = md; bus1.btn_up = bu; bus1.btn_down = bd;
        if (rst_n) push_expected();
    endtask

    task automatic idle();
        drive(6'd0, 6'd0, 5'd0, 3'b000, 1'b1, 1'b1);
    endtask

    task automatic eod();
        drive(6'd59, 6'd59, 5'd23, 3'b000, 1'b1, 1'b1);
    endtask

    task automatic press(input logic [2:0] md, input bit up);
        drive(6'd0, 6'd0, 5'd0, md, up ? 1'b0 : 1'b1, up ? 1'b1 : 1'b0);
    endtask

    // Reset in the middle of a cycle, check it takes effect with no edge,
    // hold it over one edge, then release with the current inputs held.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        st[0] = reset_state();
        st[1] = reset_state();
        check_now(st[0], st[1]);
        @(negedge clk);
        rst_n = 1'b1;
        push_expected();
    endtask

    // Step the dut0 model to the requested date using year/month/day edits.
    task automatic goto_date(input int y, input int m, input int d);
        int guard = 0;
        while (st[0].year != y && guard < 400) begin press(3'b101, 1'b1); guard++; end
        while (st[0].mon != m && guard < 400) begin press(3'b100, 1'b1); guard++; end
        while (st[0].day != d && guard < 400) begin press(3'b011, 1'b1); guard++; end
        n_checks++;
        if (guard < 400) n_pass++;
        else $display("FAIL goto_date: reached guard %0d, required below 400", guard);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t, required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus0.sec = 6'd0; bus0.min = 6'd0; bus0.hour = 5'd0; bus0.mode = 3'b000; bus0.btn_up = 1'b1; bus0.btn_down = 1'b1;
        bus1.sec = 6'd0; bus1.min = 6'd0; bus1.hour = 5'd0; bus1.mode = 3'b000; bus1.btn_up = 1'b1; bus1.btn_down = 1'b1;
        apply_reset();
        repeat (3) idle();

        // Leap February, then the non-leap century year on the 2100 instance.
        goto_date(2024, 2, 28);
        eod(); eod();
        repeat (76) press(3'b101, 1'b1);
        press(3'b100, 1'b0);
        press(3'b011, 1'b0);
        eod();

        // Century wrap by natural advance, then the same date via year edit.
        goto_date(2099, 12, 31);
        eod(); idle(); idle();
        goto_date(2099, 12, 31);
        press(3'b101, 1'b1);
        idle();

        // Month and year edit clamps.
        goto_date(2023, 1, 31);
        press(3'b100, 1'b1);
        goto_date(2024, 2, 29);
        press(3'b101, 1'b1);
        goto_date(2024, 1, 31);
        press(3'b100, 1'b0);
        goto_date(2024, 3, 31);
        press(3'b100, 1'b1);

        // Both buttons low at 30 April, then reset mid-edit and mid-rollover.
        goto_date(2001, 4, 30);
        drive(6'd0, 6'd0, 5'd0, 3'b011, 1'b0, 1'b0);
        drive(6'd0, 6'd0, 5'd0, 3'b011, 1'b0, 1'b1);
        apply_reset();
        idle();
        goto_date(2001, 12, 31);
        eod();
        apply_reset();
        idle();

`ifdef DATE_WEEKDAY_EN
        apply_reset();
        repeat (7) eod();
        for (int i = 0; i < 7 && st[0].wday != 0; i++) press(3'b110, 1'b0);
        press(3'b110, 1'b0);
        press(3'b011, 1'b1);
`endif

        // Randomized traffic, including out-of-range times and illegal modes.
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] s, mi;
            logic [4:0] h;
            if ($urandom_range(0, 1) == 0) begin
                s = 6'd59; mi = 6'd59; h = 5'd23;
            end else begin
                s = 6'($urandom_range(0, 63)); mi = 6'($urandom_range(0, 63)); h = 5'($urandom_range(0, 31));
            end
            drive(s, mi, h, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 299) == 0) apply_reset();
        end

        idle();
        @(posedge clk);
        #3;
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL drain: queue sizes %0d/%0d, required 0/0", q0.size(), q1.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
